lc2k_alu_exec: RTL and testbench
================================

// Module: lc2k_alu_exec
// PURPOSE
//  Execute stage of the single-cycle LC2K CPU: selects operand B (register B value or
//  sign-extended offset), performs add / nor / equality-compare / pass-A, and raises the
//  branch-taken flag.
//  Results are combinational for the single-cycle datapath. A registered copy plus a
//  one-cycle done pulse feed the register-file and write-data mux write enables.
//  Sits between register memory / sign extend and data memory / program mux.
// PARAMETERS
//  WIDTH  32  datapath width in bits (operands, result)
// PORTS
//  clk              in   1      system clock, rising-edge active
//  rst_n            in   1      asynchronous active-low reset
//  alu_val_a        in   WIDTH  operand A (regA value)
//  reg_b_value      in   WIDTH  regB value (operand-B candidate 0)
//  offset_extended  in   WIDTH  sign-extended 16-bit offset (operand-B candidate 1)
//  ctrl_alu_val_b   in   1      0: B=reg_b_value, 1: B=offset_extended
//  ctrl_operation   in   2      00 add, 01 nor, 10 compare(beq), 11 pass A (jalr)
//  start            in   1      instruction issue strobe, sampled on clk rise
//  alu_val_b        out  WIDTH  selected operand B (combinational)
//  alu_result       out  WIDTH  combinational result
//  ctrl_beq         out  1      branch taken: op==10 and A==B (combinational)
//  alu_result_q     out  WIDTH  registered result captured on start
//  ctrl_alu_done    out  1      one-cycle pulse, cycle after start accepted
// BEHAVIOUR
//  - Reset: clk and rst_n are the single clock and reset; rst_n is asynchronous, active-low.
//    While rst_n=0: alu_result_q=0, ctrl_alu_done=0, regardless of clk.
//    Combinational outputs follow inputs during reset.
//  - Operand mux: alu_val_b = ctrl_alu_val_b ? offset_extended : reg_b_value. Pure comb.
//  - Op 00: alu_result = A + B mod 2^WIDTH. Carry/overflow discarded, no flags.
//    Used for add, lw, sw address.
//  - Op 01: alu_result = ~(A | B), bitwise.
//  - Op 10: alu_result = A - B mod 2^WIDTH (zero iff equal).
//    ctrl_beq = (A == B), full-width compare.
//  - Op 11: alu_result = A unchanged, B ignored.
//  - ctrl_beq is 0 for every op other than 10. There is no X-propagation on defined inputs.
//  - Zero combinational latency: outputs settle in the same cycle the inputs change.
//  - Registered path, on clk rise with rst_n=1:
//    - If start=1: alu_result_q <= alu_result and ctrl_alu_done <= 1.
//    - Else: alu_result_q holds and ctrl_alu_done <= 0.
//  - Back-to-back start: done stays high each following cycle, and result_q updates every cycle.
//  - Reset asserted mid-operation clears a pending done immediately.
//    The first start after rst_n rises is accepted normally.
//  - Inputs change while start=0: no effect on registered outputs.
// TESTING
//  - Bench drives clk with a free-running 10-unit period and rst_n low for 2 cycles.
//  1. Add: A=5, reg_b=7, sel=0, op=00, start.
//     -> alu_result=12, ctrl_beq=0; next cycle alu_result_q=12, done=1 for exactly one cycle.
//  2. Offset + wrap: A=0xFFFFFFFF, offset_extended=0x00000002, sel=1, op=00
//     -> alu_val_b=2, alu_result=0x00000001.
//  3. Nor: A=0x0000FFFF, B=0x00FF00FF, op=01 -> alu_result=0xFF000000.
//  4. Beq:
//     - A=B=0x80000000, op=10 -> ctrl_beq=1, alu_result=0.
//     - A=3, B=4 -> ctrl_beq=0, alu_result=0xFFFFFFFF.
//     - op=00 with A==B -> ctrl_beq=0.
//  5. Pass: op=11, A=0x1234, B=0xDEAD -> alu_result=0x1234.
//  6. Reset/handshake:
//     - start held 3 cycles -> done high 3 cycles, result_q tracks each.
//     - Drop rst_n between edges while done=1 -> done and result_q clear immediately.

Source files
------------

// File: rtl/lc2k_alu_exec.sv
// ----------------------------------------------------------------------------
// lc2k_alu_exec
//   Execute stage of the single-cycle LC2K CPU. It picks operand B (register B
//   value or sign-extended offset), then computes add / nor / compare / pass-A
//   and raises the branch-taken flag. The result and branch flag are
//   combinational for the single-cycle datapath. A registered copy of the
//   result and a one-cycle done pulse drive the register-file and write-data
//   mux write enables.
//
// Parameters
//   WIDTH            datapath width in bits
//
// Ports
//   clk              system clock, rising-edge active
//   rst_n            asynchronous active-low reset
//   alu_val_a        operand A (regA value)
//   reg_b_value      regB value, operand-B candidate 0
//   offset_extended  sign-extended offset, operand-B candidate 1
//   ctrl_alu_val_b   operand-B select (0: reg_b_value, 1: offset_extended)
//   ctrl_operation   00 add, 01 nor, 10 compare (beq), 11 pass A (jalr)
//   start            instruction issue strobe, sampled on clk rise
//   alu_val_b        selected operand B (combinational)
//   alu_result       ALU result (combinational)
//   ctrl_beq         branch taken: compare op and A == B (combinational)
//   alu_result_q     result registered on an accepted start
//   ctrl_alu_done    one-cycle pulse in the cycle after start is accepted
// ----------------------------------------------------------------------------
module lc2k_alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_val_a,
    input  logic [WIDTH-1:0] reg_b_value,
    input  logic [WIDTH-1:0] offset_extended,
    input  logic             ctrl_alu_val_b,
    input  logic [1:0]       ctrl_operation,
    input  logic             start,
    output logic [WIDTH-1:0] alu_val_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             ctrl_beq,
    output logic [WIDTH-1:0] alu_result_q,
    output logic             ctrl_alu_done
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_NOR  = 2'b01,
        OP_BEQ  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

    alu_op_e op;
    assign op = alu_op_e'(ctrl_operation);

    assign alu_val_b = ctrl_alu_val_b ? offset_extended : reg_b_value;

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        alu_result = alu_val_a;
        ctrl_beq   = 1'b0;
        unique case (op)
            OP_ADD:  alu_result = alu_val_a + alu_val_b;
            OP_NOR:  alu_result = ~(alu_val_a | alu_val_b);
            OP_BEQ: begin
                // The difference is zero exactly when the operands match. The
                // branch flag uses a direct full-width compare, so it does not
                // depend on the subtractor.
                alu_result = alu_val_a - alu_val_b;
                ctrl_beq   = (alu_val_a == alu_val_b);
            end
            OP_PASS: alu_result = alu_val_a;
            default: alu_result = alu_val_a;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples its pre-edge inputs, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q  <= '0;
            ctrl_alu_done <= 1'b0;
        end else begin
            ctrl_alu_done <= start;
            if (start) begin
                alu_result_q <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_lc2k_alu_exec.sv
// ----------------------------------------------------------------------------
// tb_lc2k_alu_exec
//   Self-checking bench for lc2k_alu_exec. It runs directed cases for add,
//   offset wrap, nor, beq, pass-A and the handshake and reset behaviour. After
//   that it drives randomized transactions and compares them against a
//   behavioural reference model. Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_lc2k_alu_exec;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] alu_val_a;
    logic [WIDTH-1:0] reg_b_value;
    logic [WIDTH-1:0] offset_extended;
    logic             ctrl_alu_val_b;
    logic [1:0]       ctrl_operation;
    logic             start;
    logic [WIDTH-1:0] alu_val_b;
    logic [WIDTH-1:0] alu_result;
    logic             ctrl_beq;
    logic [WIDTH-1:0] alu_result_q;
    logic             ctrl_alu_done;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference-model state for the registered path.
    logic [WIDTH-1:0] model_q;
    logic             model_done;

    lc2k_alu_exec #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_val_a       (alu_val_a),
        .reg_b_value     (reg_b_value),
        .offset_extended (offset_extended),
        .ctrl_alu_val_b  (ctrl_alu_val_b),
        .ctrl_operation  (ctrl_operation),
        .start           (start),
        .alu_val_b       (alu_val_b),
        .alu_result      (alu_result),
        .ctrl_beq        (ctrl_beq),
        .alu_result_q    (alu_result_q),
        .ctrl_alu_done   (ctrl_alu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: the result follows from the operation rules with
    // plain integer arithmetic.
    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [1:0] op);
        longint unsigned sum;
        if (op == 2'd0) begin
            sum = (longint'(a) + longint'(b)) % (64'd1 << WIDTH);
            return sum[WIDTH-1:0];
        end
        if (op == 2'd1) return ~(a | b);
        if (op == 2'd2) begin
            sum = ((64'd1 << WIDTH) + longint'(a) - longint'(b)) % (64'd1 << WIDTH);
            return sum[WIDTH-1:0];
        end
        return a;
    endfunction

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] rb,
                         input logic [WIDTH-1:0] off, input logic sel,
                         input logic [1:0] op, input logic st);
        alu_val_a       = a;
        reg_b_value     = rb;
        offset_extended = off;
        ctrl_alu_val_b  = sel;
        ctrl_operation  = op;
        start           = st;
    endtask

    // Advance one rising edge and update the model with the pre-edge inputs.
    // Sampling then happens on the following falling edge.
    task automatic tick();
        logic [WIDTH-1:0] b;
        b = ctrl_alu_val_b ? offset_extended : reg_b_value;
        @(posedge clk);
        if (rst_n) begin
            model_done = start;
            if (start) model_q = ref_result(alu_val_a, b, ctrl_operation);
        end
        @(negedge clk);
    endtask

    task automatic check_comb(input string tag);
        logic [WIDTH-1:0] b;
        b = ctrl_alu_val_b ? offset_extended : reg_b_value;
        check({tag, "_b"},   alu_val_b, b);
        check({tag, "_res"}, alu_result, ref_result(alu_val_a, b, ctrl_operation));
        check({tag, "_beq"}, WIDTH'(ctrl_beq),
              WIDTH'((ctrl_operation == 2'd2) && (alu_val_a == b)));
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_q"},    alu_result_q, model_q);
        check({tag, "_done"}, WIDTH'(ctrl_alu_done), WIDTH'(model_done));
    endtask

    initial begin
        model_q    = '0;
        model_done = 1'b0;
        rst_n      = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("reset_q",    alu_result_q, 32'd0);
        check("reset_done", WIDTH'(ctrl_alu_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. add with handshake
        drive(32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 1'b1);
        #1;
        check("add_res", alu_result, 32'd12);
        check("add_beq", WIDTH'(ctrl_beq), 32'd0);
        @(negedge clk);
        tick();
        start = 1'b0;
        check("add_q",    alu_result_q, 32'd12);
        check("add_done", WIDTH'(ctrl_alu_done), 32'd1);
        tick();
        check("add_done_pulse", WIDTH'(ctrl_alu_done), 32'd0);
        check("add_q_hold",     alu_result_q, 32'd12);

        // 2. offset + wrap
        drive(32'hFFFF_FFFF, 32'h55, 32'h2, 1'b1, 2'b00, 1'b0);
        #1;
        check("wrap_b",   alu_val_b, 32'd2);
        check("wrap_res", alu_result, 32'd1);

        // 3. nor
        drive(32'h0000_FFFF, 32'h00FF_00FF, 32'h0, 1'b0, 2'b01, 1'b0);
        #1;
        check("nor_res", alu_result, 32'hFF00_0000);

        // 4. beq
        drive(32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 2'b10, 1'b0);
        #1;
        check("beq_eq_flag", WIDTH'(ctrl_beq), 32'd1);
        check("beq_eq_res",  alu_result, 32'd0);
        drive(32'd3, 32'd4, 32'h0, 1'b0, 2'b10, 1'b0);
        #1;
        check("beq_ne_flag", WIDTH'(ctrl_beq), 32'd0);
        check("beq_ne_res",  alu_result, 32'hFFFF_FFFF);
        drive(32'd9, 32'd9, 32'h0, 1'b0, 2'b00, 1'b0);
        #1;
        check("beq_addop_flag", WIDTH'(ctrl_beq), 32'd0);

        // 5. pass A
        drive(32'h1234, 32'hDEAD, 32'h0, 1'b0, 2'b11, 1'b0);
        #1;
        check("pass_res", alu_result, 32'h1234);
        @(negedge clk);

        // 6. back-to-back start for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(32'(100 * (i + 1)), 32'(i + 1), 32'h0, 1'b0, 2'b00, 1'b1);
            tick();
            check($sformatf("b2b%0d_q", i), alu_result_q, 32'(100 * (i + 1) + i + 1));
            check($sformatf("b2b%0d_done", i), WIDTH'(ctrl_alu_done), 32'd1);
        end
        start = 1'b0;
        // Assert reset between edges while done is high.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_done", WIDTH'(ctrl_alu_done), 32'd0);
        check("async_rst_q",    alu_result_q, 32'd0);
        model_q    = '0;
        model_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // The first start after reset is accepted.
        drive(32'd40, 32'd2, 32'h0, 1'b0, 2'b00, 1'b1);
        tick();
        check("post_rst_q",    alu_result_q, 32'd42);
        check("post_rst_done", WIDTH'(ctrl_alu_done), 32'd1);

        // Randomized traffic against the model. A==B is forced on some draws.
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] a, rb, off;
            a   = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            off = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(a, rb, off, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            #1;
            check_comb($sformatf("rnd%0d", i));
            @(negedge clk);
            tick();
            check_regs($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
